// File: rtl/vram_wr_sched.sv
// Write-port scheduler for the 80x60 character VRAM: round-robin between two
// requesters, full-screen clear engine, window-gated issue and bank mapping.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate req0/req1 while wr_win is high; accept clr_start
// S_CLEAR | sweep every cell with the captured fill word, one per wr_win cycle
module vram_wr_sched #(
  parameter int P_CELLS       = 4800,
  parameter int P_BANK1_WORDS = 1024,
  parameter int P_ADR_W       = 13,
  parameter int P_DAT_W       = 72
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_win,
  input  logic               req0_valid,
  input  logic [P_ADR_W-1:0] req0_adr,
  input  logic [P_DAT_W-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [P_ADR_W-1:0] req1_adr,
  input  logic [P_DAT_W-1:0] req1_data,
  output logic               req1_ready,
  input  logic               clr_start,
  input  logic [P_DAT_W-1:0] clr_data,
  output logic               clr_busy,
  output logic [P_DAT_W-1:0] vram_wr_data,
  output logic [9:0]         vram_wr_adr_1,
  output logic [11:0]        vram_wr_adr_2,
  output logic               vram_wr_en_1,
  output logic               vram_wr_en_2,
  output logic               err_adr,
  input  logic               err_clr
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [P_ADR_W-1:0] CELLS_L = P_ADR_W'(P_CELLS);
  localparam logic [P_ADR_W-1:0] LAST_L  = P_ADR_W'(P_CELLS - 1);
  localparam logic [P_ADR_W-1:0] BANK1_L = P_ADR_W'(P_BANK1_WORDS);

  state_t               state_q, state_d;
  logic [P_ADR_W-1:0]   cnt_q, cnt_d;
  logic [P_DAT_W-1:0]   fill_q, fill_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 busy_q;
  logic                 gnt0, gnt1;
  logic                 wr_issue;
  logic                 adr_bad;
  logic [P_ADR_W-1:0]   wr_adr;
  logic [P_DAT_W-1:0]   wr_dat;
  logic                 wr_bank1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    last_gnt_d = last_gnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    wr_issue   = 1'b0;
    adr_bad    = 1'b0;
    wr_adr     = req0_adr;
    wr_dat     = req0_data;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          fill_d  = clr_data;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else if (wr_win && !busy_q && !rst) begin
          // on a tie, grant whichever requester was not served last
          if (req0_valid && (!req1_valid || last_gnt_q)) gnt0 = 1'b1;
          else if (req1_valid)                           gnt1 = 1'b1;
          if (gnt1) begin
            wr_adr = req1_adr;
            wr_dat = req1_data;
          end
          if (gnt0 || gnt1) begin
            last_gnt_d = gnt1;
            if (wr_adr < CELLS_L) wr_issue = 1'b1;
            else                  adr_bad  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (wr_win) begin
          wr_issue = 1'b1;
          wr_adr   = cnt_q;
          wr_dat   = fill_q;
          if (cnt_q == LAST_L) state_d = S_IDLE;
          else                 cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wr_bank1   = (wr_adr < BANK1_L);
  assign clr_busy   = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      last_gnt_q <= 1'b1;
      busy_q     <= 1'b0;
      err_adr    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      last_gnt_q <= last_gnt_d;
      // stays high one extra cycle so it covers the final write being presented
      busy_q     <= (state_d == S_CLEAR) || (state_q == S_CLEAR);
      if (adr_bad)      err_adr <= 1'b1;
      else if (err_clr) err_adr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_wr_en_1  <= 1'b0;
      vram_wr_en_2  <= 1'b0;
      vram_wr_data  <= '0;
      vram_wr_adr_1 <= '0;
      vram_wr_adr_2 <= '0;
    end else begin
      vram_wr_en_1 <= wr_issue && wr_bank1;
      vram_wr_en_2 <= wr_issue && !wr_bank1;
      if (wr_issue) begin
        vram_wr_data <= wr_dat;
        if (wr_bank1) vram_wr_adr_1 <= wr_adr[9:0];
        else          vram_wr_adr_2 <= 12'(wr_adr - BANK1_L);
      end
    end
  end

endmodule

// File: tb/tb_vram_wr_sched.sv
// Scoreboard bench for vram_wr_sched: a cell-level reference model predicts
// grants, writes, clr_busy and err_adr; a monitor checks every presented write.
module tb_vram_wr_sched;

  localparam int CELLS = 4800;
  localparam int B1    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_win;
  logic        req0_valid, req1_valid;
  logic [12:0] req0_adr, req1_adr;
  logic [71:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clr_start;
  logic [71:0] clr_data;
  logic        clr_busy;
  logic [71:0] vram_wr_data;
  logic [9:0]  vram_wr_adr_1;
  logic [11:0] vram_wr_adr_2;
  logic        vram_wr_en_1, vram_wr_en_2;
  logic        err_adr;
  logic        err_clr;

  vram_wr_sched dut (
    .clk(clk), .rst(rst), .wr_win(wr_win),
    .req0_valid(req0_valid), .req0_adr(req0_adr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
    .vram_wr_data(vram_wr_data), .vram_wr_adr_1(vram_wr_adr_1), .vram_wr_adr_2(vram_wr_adr_2),
    .vram_wr_en_1(vram_wr_en_1), .vram_wr_en_2(vram_wr_en_2),
    .err_adr(err_adr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bank2;
    int          adr;
    logic [71:0] data;
    int          due;
  } wr_t;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_en1 = 0, n_en2 = 0;

  // reference model state
  bit          m_clearing, m_hold, m_err;
  int          m_ptr, m_last;
  logic [71:0] m_fill;
  int          win_mode;   // 0 high, 1 toggle, 2 random, 3 low
  int          req_mode;   // 0 hold after accept, 1 drop, 2 random refill
  int          acc;
  bit          s_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  function automatic logic [12:0] rnd_adr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 13'd1023;
      1: return 13'd1024;
      2: return 13'd4799;
      3: return 13'($urandom_range(4800, 8191));
      4: return 13'd0;
      default: return 13'($urandom_range(0, 4799));
    endcase
  endfunction

  task automatic push(input int a, input logic [71:0] d);
    wr_t e;
    e.bank2 = (a >= B1);
    e.adr   = (a >= B1) ? a - B1 : a;
    e.data  = d;
    e.due   = cyc + 1;
    sb.push_back(e);
  endtask

  // write monitor
  always @(negedge clk) begin
    if (!rst) begin
      wr_t e;
      chk("en_exclusive", int'(vram_wr_en_1 & vram_wr_en_2), 0);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missed_write: got none expected adr %0d bank2 %0d due %0d", sb[0].adr, sb[0].bank2, sb[0].due);
        void'(sb.pop_front());
      end
      if (vram_wr_en_1 || vram_wr_en_2) begin
        if (vram_wr_en_1) n_en1++;
        if (vram_wr_en_2) n_en2++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_write: got en1 %0d en2 %0d expected no write (cycle %0d)", vram_wr_en_1, vram_wr_en_2, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_bank2", int'(vram_wr_en_2), int'(e.bank2));
          chk("wr_adr", vram_wr_en_2 ? int'(vram_wr_adr_2) : int'(vram_wr_adr_1), e.adr);
          chkd("wr_data", vram_wr_data, e.data);
          chk("wr_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic new_req(input int k);
    if (k == 0) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_adr   = rnd_adr();
      req0_data  = rnd72();
    end else begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_adr   = rnd_adr();
      req1_data  = rnd72();
    end
  endtask

  // one clock cycle: predict, compare, advance model, then update requesters
  task automatic step();
    int  w;
    int  a;
    bit  e0, e1, hold_nx, set_err;
    case (win_mode)
      0:       wr_win = 1'b1;
      1:       wr_win = ~wr_win;
      2:       wr_win = 1'($urandom_range(0, 1));
      default: wr_win = 1'b0;
    endcase
    @(negedge clk);
    chk("clr_busy", int'(clr_busy), int'(m_clearing || m_hold));
    chk("err_adr", int'(err_adr), int'(m_err));
    w = -1; e0 = 0; e1 = 0; hold_nx = 0; set_err = 0;
    if (m_clearing) begin
      if (wr_win) begin
        push(m_ptr, m_fill);
        m_ptr++;
        if (m_ptr == CELLS) begin
          m_clearing = 0;
          hold_nx    = 1;
        end
      end
    end else if (clr_start) begin
      m_clearing = 1;
      m_fill     = clr_data;
      m_ptr      = 0;
    end else if (!m_hold && wr_win) begin
      if (req0_valid && req1_valid) w = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
      if (w >= 0) begin
        e0 = (w == 0);
        e1 = (w == 1);
        m_last = w;
        a = (w == 1) ? int'(req1_adr) : int'(req0_adr);
        if (a < CELLS) push(a, (w == 1) ? req1_data : req0_data);
        else           set_err = 1;
      end
    end
    chk("req0_ready", int'(req0_ready), int'(e0));
    chk("req1_ready", int'(req1_ready), int'(e1));
    s_busy = clr_busy;
    m_hold = hold_nx;
    if (set_err)      m_err = 1;
    else if (err_clr) m_err = 0;
    @(posedge clk);
    #1;
    acc = w;
    if (req_mode == 1) begin
      if (w == 0) req0_valid = 1'b0;
      if (w == 1) req1_valid = 1'b0;
    end else if (req_mode == 2) begin
      if (w == 0 || !req0_valid) new_req(0);
      if (w == 1 || !req1_valid) new_req(1);
    end
  endtask

  task automatic send(input int k, input logic [12:0] adr, input int maxcyc);
    bit done;
    done = 0;
    if (k == 0) begin req0_valid = 1'b1; req0_adr = adr; req0_data = rnd72(); end
    else        begin req1_valid = 1'b1; req1_adr = adr; req1_data = rnd72(); end
    for (int i = 0; i < maxcyc && !done; i++) begin
      step();
      if (acc == k) done = 1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected req%0d adr %0d", k, adr);
    end
  endtask

  task automatic model_reset();
    m_clearing = 0; m_hold = 0; m_err = 0; m_ptr = 0; m_last = 1; m_fill = '0;
  endtask

  task automatic pulse_clear(input logic [71:0] d);
    clr_data  = d;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
  endtask

  task automatic run_clear_to_end(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 12000 && (m_clearing || m_hold); i++) begin
      step();
      if (s_busy) nbusy++;
    end
    chk("clear_terminated", int'(m_clearing || m_hold), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en1"},  int'(vram_wr_en_1), 0);
    chk({tag, "_en2"},  int'(vram_wr_en_2), 0);
    chk({tag, "_adr1"}, int'(vram_wr_adr_1), 0);
    chk({tag, "_adr2"}, int'(vram_wr_adr_2), 0);
    chkd({tag, "_data"}, vram_wr_data, 72'h0);
    chk({tag, "_busy"}, int'(clr_busy), 0);
    chk({tag, "_err"},  int'(err_adr), 0);
    chk({tag, "_rdy0"}, int'(req0_ready), 0);
    chk({tag, "_rdy1"}, int'(req1_ready), 0);
  endtask

  initial begin
    int nbusy;
    rst = 1'b1; wr_win = 1'b0; clr_start = 1'b0; clr_data = '0; err_clr = 1'b0;
    req0_valid = 1'b0; req0_adr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_adr = '0; req1_data = '0;
    win_mode = 0; req_mode = 1; acc = -1; s_busy = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // alternating grants on a continuous tie
    req_mode = 0;
    req0_valid = 1'b1; req0_adr = 13'd5;    req0_data = rnd72();
    req1_valid = 1'b1; req1_adr = 13'd1030; req1_data = rnd72();
    for (int i = 0; i < 8; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req_mode = 1;
    step(); step();

    // window gating and the bank 1/2 boundary
    win_mode = 1;
    send(0, 13'd1023, 10);
    send(0, 13'd1024, 10);
    send(1, 13'd4799, 10);
    win_mode = 0;
    step(); step();

    // sticky error with set/clear collision
    send(1, 13'd4800, 5);
    step();
    chk("err_set", int'(err_adr), 1);
    err_clr = 1'b1;
    send(1, 13'd4800, 5);
    err_clr = 1'b0;
    step();
    chk("err_set_wins", int'(err_adr), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("err_cleared", int'(err_adr), 0);

    // full clear with requests pending throughout
    n_en1 = 0; n_en2 = 0;
    pulse_clear(72'h07_FF818181818181FF);
    req_mode = 0;
    req0_valid = 1'b1; req0_adr = 13'd77;   req0_data = rnd72();
    req1_valid = 1'b1; req1_adr = 13'd2222; req1_data = rnd72();
    run_clear_to_end(nbusy);
    chk("clear_busy_cycles", nbusy, CELLS + 1);
    chk("clear_bank1_writes", n_en1, B1);
    chk("clear_bank2_writes", n_en2, CELLS - B1);
    req_mode = 1;
    step();
    chk("first_grant_after_clear", int'(acc), 0);
    for (int i = 0; i < 4; i++) step();

    // paused clear with an ignored restart
    n_en1 = 0; n_en2 = 0;
    pulse_clear(rnd72());
    for (int i = 0; i < 6000 && m_ptr < 2000; i++) step();
    win_mode = 3;
    for (int i = 0; i < 100; i++) step();
    chk("pause_holds_position", m_ptr, 2000);
    win_mode = 0;
    for (int i = 0; i < 6000 && m_ptr < 3000; i++) step();
    pulse_clear(rnd72());
    run_clear_to_end(nbusy);
    chk("paused_clear_writes", n_en1 + n_en2, CELLS);
    step(); step();

    // reset in the middle of a clear
    pulse_clear(rnd72());
    for (int i = 0; i < 6000 && m_ptr < 500; i++) step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midclr_rst");
    model_reset();
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    req_mode = 1;
    req0_adr = 13'd9; req1_adr = 13'd10;
    step();
    chk("tie_after_rst", int'(acc), 0);
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    win_mode = 2; req_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    err_clr = 1'b0;
    req_mode = 1; req0_valid = 1'b0; req1_valid = 1'b0; win_mode = 0;
    step(); step(); step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
